quad_step_counter_mc: RTL and testbench
=======================================

# quad_step_counter_mc

Multi-channel quadrature step counter with per-channel programmable limits, direction-aware counting and a byte-wide read/write register interface. Successor to the single-channel limit counter: it adds N channels, input synchronisation, signed up/down mode, illegal-transition detection, atomic 16-bit register access and an interrupt output. Sits on the 8-bit peripheral bus beside the other memory-mapped peripherals and drives encoder-based motion limits.

## Interface

- CHANNELS, 2, number of independent encoder channels (1..8)
- CNT_W, 16, counter/limit width in bits (9..16); unused high bits read 0, ignored on write
- SYNC_STAGES, 2, synchroniser flops on each A/B input (>=2)
- ADDR_W, 8, bus address width; must hold CHANNELS*8
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  ADDR_W  byte address; channel = addr[ADDR_W-1:3], offset = addr[2:0]
- cs  in  1  chip select
- rd  in  1  read strobe (with cs)
- wr  in  1  write strobe (with cs)
- wdata  in  8  write data
- rdata  out  8  registered read data
- a  in  CHANNELS  encoder phase A, asynchronous
- b  in  CHANNELS  encoder phase B, asynchronous
- done  out  CHANNELS  per-channel limit-reached flag
- irq  out  1  OR over channels of done & IRQ_EN

## Operation

- Per-channel map (offset): 0 COUNT_L (RO), 1 COUNT_H (RO), 2 LIMIT_L (RW), 3 LIMIT_H (RW), 4 CTRL (RW: bit0 EN, bit1 MODE, bit2 IRQ_EN), 5 STATUS (bit0 DONE, bit1 ERR, bit2 DIR; W1C on bits 0-1), 6 CMD (WO: bit0 CLEAR), 7 reserved (reads 0). Channel index >= CHANNELS reads 0, writes ignored.
- Inputs pass through SYNC_STAGES flops; transition decode uses synced {a,b} against prev sample.
- Forward (up) transitions: 00->01, 01->11, 11->10, 10->00. Reverse: 00->10, 10->11, 11->01, 01->00. Both bits changing = illegal: ERR set (sticky), no count. No change = no action.
- Priming: after reset or EN 0->1, first synced sample loads prev without counting.
- MODE=0 (absolute): any valid step increments count. DONE sets when count >= limit and limit != 0.
- MODE=1 (signed): forward +1, reverse -1, two's complement, wraps modulo 2^CNT_W. DONE sets when count == limit and limit != 0.
- DIR = direction of last valid step (1 = forward).
- While DONE=1 or EN=0, count frozen; prev sample still tracks when EN=1.
- CLEAR (CMD bit0=1): count := 0, DONE := 0, ERR untouched. Writing 1 to STATUS bit0 clears DONE only; bit1 clears ERR.
- LIMIT_L write goes to a staging byte; LIMIT_H write commits {wdata, staging} atomically. Reads return committed limit.
- COUNT_L read captures count high byte into a shadow; COUNT_H returns the shadow (coherent 16-bit read, low byte first).

## Timing

- Reset: rdata=0, done=0, irq=0; count, limit, staging, shadow, CTRL, ERR, DIR = 0; prev = 00, unprimed; sync flops 0.
- Input edge to count update: SYNC_STAGES+1 clk.
- DONE rises the clk after the count meeting the condition is registered; irq same clk as done (combinational from registers).
- Read: cs&rd sampled at edge N, rdata valid after edge N; rdata holds last value when no read.
- Write: cs&wr sampled at edge N; new register value visible from N+1. cs&rd&wr together: write performed, read ignored.
- Step and CLEAR same clk: CLEAR wins, count = 0. Step and limit commit same clk: step applied, compare uses new limit next clk.
- Async reset mid-count: all state returns to reset values immediately; channel re-primes after release.

## Test plan

- Reset release, ch0 EN=1 MODE=0, limit 0x0005, 5 forward steps -> count=5, done[0]=1 two clk later, further steps leave count=5.
- ch1 MODE=1, limit 0xFFFE, 2 reverse steps from 0 -> count=0xFFFE, done[1]=1; IRQ_EN=1 -> irq=1; W1C STATUS bit0 -> irq=0.
- Inject 00->11 on ch0 -> ERR=1, count unchanged; W1C bit1 -> ERR=0.
- Count 0x01FF, read COUNT_L (0xFF), step to 0x0200, read COUNT_H -> 0x01 (shadow).
- Write LIMIT_L=0x34 only -> LIMIT reads old value; write LIMIT_H=0x12 -> reads 0x1234.
- Encoder held at 11 through reset/EN enable -> no spurious count; CLEAR coincident with step -> count=0.

Source files
------------

// File: rtl/quad_step_counter_mc.sv
// Multi-channel quadrature step counter: per-channel limit, absolute/signed modes, byte register bus.
// Latency: encoder edge to count SYNC_STAGES+1 clk, done one clk later; bus read data registered (1 clk).
// Backpressure: none; the bus is always ready and encoder steps are never stalled, only frozen by DONE/EN.
module quad_step_counter_mc #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                cs,
  input  logic                rd,
  input  logic                wr,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  output logic [CHANNELS-1:0] done,
  output logic                irq
);

  localparam int CHW = ADDR_W - 3;

  logic [CHW-1:0]      chan;
  logic [2:0]          off;
  logic                rd_en;
  logic                wr_en;
  logic [7:0]          rd_byte;
  logic [CHANNELS-1:0] irq_en_v;

  logic [15:0] cnt_x    [CHANNELS];
  logic [15:0] lim_x    [CHANNELS];
  logic [7:0]  shadow_x [CHANNELS];
  logic [2:0]  ctrl_x   [CHANNELS];
  logic [2:0]  stat_x   [CHANNELS];

  assign chan  = addr[ADDR_W-1:3];
  assign off   = addr[2:0];
  // A simultaneous read and write performs only the write.
  assign wr_en = cs & wr;
  assign rd_en = cs & rd & ~wr;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [CHW-1:0] CH_ID = CHW'(g);

    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic [1:0]       ab, prev;
    logic             primed, en, mode, irq_en, done_r, err, dir, chk;
    logic [CNT_W-1:0] count, limit;
    logic [7:0]       stage, shadow;
    logic             sel_w, fwd, rev, illegal, active, step_ok, count_go;
    logic             clr, w1c_done, w1c_err, lim_commit, ctrl_wr, hit;
    logic [15:0]      lim_full;

    assign ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    assign fwd = (prev == 2'b00 && ab == 2'b01) || (prev == 2'b01 && ab == 2'b11) ||
                 (prev == 2'b11 && ab == 2'b10) || (prev == 2'b10 && ab == 2'b00);
    assign rev = (prev == 2'b00 && ab == 2'b10) || (prev == 2'b10 && ab == 2'b11) ||
                 (prev == 2'b11 && ab == 2'b01) || (prev == 2'b01 && ab == 2'b00);
    assign illegal  = (prev ^ ab) == 2'b11;
    assign active   = en & primed;
    assign step_ok  = active & (fwd | rev);
    assign count_go = step_ok & ~done_r;

    assign sel_w      = wr_en && (chan == CH_ID);
    assign lim_commit = sel_w && (off == 3'd3);
    assign ctrl_wr    = sel_w && (off == 3'd4);
    assign w1c_done   = sel_w && (off == 3'd5) && wdata[0];
    assign w1c_err    = sel_w && (off == 3'd5) && wdata[1];
    assign clr        = sel_w && (off == 3'd6) && wdata[0];
    assign lim_full   = {wdata, stage};

    assign hit = (limit != '0) && (mode ? (count == limit) : (count >= limit));

    // Synchronise the asynchronous encoder phases.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_a <= '0;
        sync_b <= '0;
      end else begin
        sync_a <= {sync_a[SYNC_STAGES-2:0], a[g]};
        sync_b <= {sync_b[SYNC_STAGES-2:0], b[g]};
      end
    end

    // Decode steps, update count/flags, and take register writes for this channel.
    // DONE is evaluated only on the clock after count, limit or control changed, so an
    // acknowledged DONE stays clear until the count moves again.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prev   <= 2'b00;
        primed <= 1'b0;
        count  <= '0;
        limit  <= '0;
        stage  <= '0;
        en     <= 1'b0;
        mode   <= 1'b0;
        irq_en <= 1'b0;
        done_r <= 1'b0;
        err    <= 1'b0;
        dir    <= 1'b0;
        chk    <= 1'b0;
      end else begin
        if (en) begin
          prev   <= ab;
          primed <= 1'b1;
        end else begin
          primed <= 1'b0;
        end

        if (clr)
          count <= '0;
        else if (count_go)
          count <= (mode && rev) ? count - CNT_W'(1) : count + CNT_W'(1);

        if (step_ok)
          dir <= fwd;

        if (active && illegal)
          err <= 1'b1;
        else if (w1c_err)
          err <= 1'b0;

        if (clr || w1c_done)
          done_r <= 1'b0;
        else if (chk && hit)
          done_r <= 1'b1;

        chk <= clr | count_go | lim_commit | ctrl_wr;

        if (sel_w && off == 3'd2)
          stage <= wdata;
        if (lim_commit)
          limit <= lim_full[CNT_W-1:0];
        if (ctrl_wr) begin
          en     <= wdata[0];
          mode   <= wdata[1];
          irq_en <= wdata[2];
        end
      end
    end

    // Capture the count high byte when the low byte is read, for a coherent 16-bit read.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        shadow <= '0;
      else if (rd_en && chan == CH_ID && off == 3'd0)
        shadow <= cnt_x[g][15:8];
    end

    assign cnt_x[g]    = 16'(count);
    assign lim_x[g]    = 16'(limit);
    assign shadow_x[g] = shadow;
    assign ctrl_x[g]   = {irq_en, mode, en};
    assign stat_x[g]   = {dir, err, done_r};
    assign done[g]     = done_r;
    assign irq_en_v[g] = irq_en;
  end

  // Select the addressed register byte; absent channels and reserved offsets read 0.
  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan == CHW'(i)) begin
        case (off)
          3'd0:    rd_byte = cnt_x[i][7:0];
          3'd1:    rd_byte = shadow_x[i];
          3'd2:    rd_byte = lim_x[i][7:0];
          3'd3:    rd_byte = lim_x[i][15:8];
          3'd4:    rd_byte = {5'b0, ctrl_x[i]};
          3'd5:    rd_byte = {5'b0, stat_x[i]};
          default: rd_byte = '0;
        endcase
      end
    end
  end

  // Register read data; hold the last value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata <= '0;
    else if (rd_en)
      rdata <= rd_byte;
  end

  assign irq = |(done & irq_en_v);

endmodule

// File: tb/tb_quad_step_counter_mc.sv
// Directed bench for quad_step_counter_mc with a queue-based scoreboard.
// Stimulus pushes expected bytes; a monitor pops and compares when the DUT presents a result.
// Inputs are driven on the falling edge, results sampled on the falling edge after the active edge.
module tb_quad_step_counter_mc;

  localparam int CH = 2;

  logic          clk;
  logic          rst_n;
  logic [7:0]    addr;
  logic          cs, rd, wr;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic [CH-1:0] a, b;
  logic [CH-1:0] done;
  logic          irq;

  quad_step_counter_mc #(.CHANNELS(CH), .CNT_W(16), .SYNC_STAGES(2), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .cs(cs), .rd(rd), .wr(wr),
    .wdata(wdata), .rdata(rdata), .a(a), .b(b), .done(done), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = read response, 1 = {irq, done} pins, 2 = rdata hold peek
  typedef struct {
    string      name;
    logic [7:0] exp;
    int         kind;
  } item_t;

  item_t sb_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  logic  rd_fire_q = 1'b0;
  logic  probe = 1'b0, probe_q = 1'b0;
  int    probe_kind = 1;
  logic  final_chk = 1'b0;

  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         idx [CH];

  // Mark cycles in which the DUT produces something to check.
  always @(posedge clk) begin
    rd_fire_q <= cs & rd & ~wr;
    probe_q   <= probe;
  end

  // Monitor: pop expected entries and compare against the DUT.
  always @(negedge clk) begin
    item_t      it;
    logic [7:0] act;
    if (rd_fire_q || probe_q) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: rdata=%02h done=%b irq=%b, scoreboard empty", rdata, done, irq);
      end else begin
        it  = sb_q.pop_front();
        act = (it.kind == 1) ? {5'b0, irq, done} : rdata;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %02h expected %02h", it.name, act, it.exp);
        end
      end
    end
    if (final_chk) begin
      n_cmp++;
      if (sb_q.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input int ch, input int off, input logic [7:0] d);
    addr = 8'(ch * 8 + off); wdata = d; cs = 1'b1; wr = 1'b1;
    @(posedge clk); @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic expect_rd(input int ch, input int off, input logic [7:0] e, input string nm);
    item_t it;
    it.name = nm; it.exp = e; it.kind = 0;
    sb_q.push_back(it);
    addr = 8'(ch * 8 + off); cs = 1'b1; rd = 1'b1;
    @(posedge clk); @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic expect_out(input int kind, input logic [7:0] e, input string nm);
    item_t it;
    it.name = nm; it.exp = e; it.kind = kind;
    sb_q.push_back(it);
    probe = 1'b1;
    @(posedge clk); @(negedge clk);
    probe = 1'b0;
  endtask

  task automatic set_ab(input int ch);
    logic [1:0] v;
    v = seq[idx[ch]];
    a[ch] = v[1];
    b[ch] = v[0];
  endtask

  task automatic step(input int ch, input bit fwd);
    idx[ch] = fwd ? (idx[ch] + 1) % 4 : (idx[ch] + 3) % 4;
    set_ab(ch);
    idle(4);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    a = '0; b = '0;
    for (int i = 0; i < CH; i++) idx[i] = 0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Reset state
    expect_out(1, 8'h00, "reset_done_irq");
    expect_rd(0, 0, 8'h00, "reset_count_l");
    expect_rd(0, 4, 8'h00, "reset_ctrl");
    expect_rd(1, 3, 8'h00, "reset_limit_h");

    // ch0 absolute mode, limit 5
    bus_write(0, 2, 8'h05);
    bus_write(0, 3, 8'h00);
    bus_write(0, 4, 8'h01);
    idle(4);
    for (int i = 0; i < 5; i++) step(0, 1'b1);
    expect_rd(0, 0, 8'h05, "abs_count_5");
    expect_rd(0, 1, 8'h00, "abs_count_h");
    expect_out(1, 8'h01, "abs_done0");
    step(0, 1'b1);
    step(0, 1'b1);
    expect_rd(0, 0, 8'h05, "abs_frozen");
    expect_rd(0, 5, 8'h05, "abs_status");
    expect_out(2, 8'h05, "rdata_hold");

    // ch1 signed mode, limit 0xFFFE, two reverse steps
    bus_write(1, 2, 8'hFE);
    bus_write(1, 3, 8'hFF);
    bus_write(1, 4, 8'h03);
    idle(4);
    step(1, 1'b0);
    step(1, 1'b0);
    expect_rd(1, 0, 8'hFE, "sgn_count_l");
    expect_rd(1, 1, 8'hFF, "sgn_count_h");
    expect_out(1, 8'h03, "sgn_done_no_irq");
    expect_rd(1, 5, 8'h01, "sgn_status");
    bus_write(1, 4, 8'h07);
    expect_out(1, 8'h07, "irq_set");
    bus_write(1, 5, 8'h01);
    expect_out(1, 8'h01, "w1c_done_irq_clear");

    // Illegal transition on ch1 (11 -> 00)
    idx[1] = (idx[1] + 2) % 4;
    set_ab(1);
    idle(4);
    expect_rd(1, 0, 8'hFE, "err_count_unchanged");
    expect_rd(1, 5, 8'h02, "err_set");
    bus_write(1, 5, 8'h02);
    expect_rd(1, 5, 8'h00, "err_w1c");

    // Coherent 16-bit count read on ch0
    bus_write(0, 2, 8'h00);
    bus_write(0, 3, 8'h00);
    bus_write(0, 6, 8'h01);
    expect_out(1, 8'h00, "clear_done");
    for (int i = 0; i < 511; i++) step(0, 1'b1);
    expect_rd(0, 0, 8'hFF, "shadow_low");
    step(0, 1'b1);
    expect_rd(0, 1, 8'h01, "shadow_high");
    expect_rd(0, 0, 8'h00, "count_200_low");
    expect_rd(0, 1, 8'h02, "count_200_high");

    // Staged limit commit
    bus_write(0, 2, 8'h34);
    expect_rd(0, 2, 8'h00, "stage_low_hidden");
    expect_rd(0, 3, 8'h00, "stage_high_hidden");
    bus_write(0, 3, 8'h12);
    expect_rd(0, 2, 8'h34, "commit_low");
    expect_rd(0, 3, 8'h12, "commit_high");

    // Absent channel and reserved offsets
    bus_write(2, 2, 8'hAA);
    expect_rd(2, 2, 8'h00, "absent_channel");
    expect_rd(0, 7, 8'h00, "reserved_off");
    expect_rd(0, 6, 8'h00, "cmd_reads_0");

    // Encoder held at 11 through reset and enable
    idx[0] = 2;
    set_ab(0);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    expect_out(1, 8'h00, "async_reset_pins");
    rst_n = 1'b1;
    idle(2);
    expect_rd(0, 3, 8'h00, "reset_limit_cleared");
    bus_write(0, 4, 8'h01);
    idle(6);
    expect_rd(0, 0, 8'h00, "no_spurious_count");
    expect_rd(0, 5, 8'h00, "no_spurious_err");
    step(0, 1'b1);
    expect_rd(0, 0, 8'h01, "step_after_prime");

    // CLEAR in the same clock as a step: clear wins
    idx[0] = (idx[0] + 1) % 4;
    set_ab(0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    bus_write(0, 6, 8'h01);
    idle(3);
    expect_rd(0, 0, 8'h00, "clear_beats_step");
    expect_rd(0, 5, 8'h04, "dir_after_clear");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
    final_chk = 1'b1;
    idle(1);
    final_chk = 1'b0;
    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
